// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared types and constants for the RTC bus sequencer.
// Holds the FSM state enum, idle strobe levels and phases per access.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A_SET,
    S_A_STB,
    S_A_HLD,
    S_D_SET,
    S_D_STB,
    S_D_HLD,
    S_GAP
  } state_e;

  typedef struct packed {
    logic cs;
    logic ad;
    logic rd;
    logic wr;
  } strobe_t;

  localparam strobe_t STB_IDLE = '{
    cs: 1'b1, ad: 1'b1, rd: 1'b1, wr: 1'b1
  };

  // Bus phases per register access, IDLE excluded.
  localparam int unsigned N_PHASES = 7;

endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: per-state phase down-counter for the RTC bus sequencer.
// Ports: Clk, Reset (async low), load (state entry), expired (count at 0).
module rtc_phase_timer #(
  parameter int T_PHASE = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  output logic expired
);

  localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam logic [CW-1:0] LOAD_V = CW'(T_PHASE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Sits at zero while the FSM stalls, so expiry persists.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = LOAD_V;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: address/data burst engine for the muxed RTC bus.
// Ports: cmd_* handshake, abort, wr_* data in, rd_* data out, busy/done/
// aborted status, AD/CS/RD/WR strobes (low), bus_out/bus_oe/bus_in and
// the Data_Bus tristate.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int T_PHASE   = 4,
  parameter int BURST_MAX = 16,
  parameter int LEN_W     = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              AD,
  output logic              CS,
  output logic              RD,
  output logic              WR,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in,
  inout  wire  [DATA_W-1:0] Data_Bus
);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              abort_q, abort_d;
  strobe_t           stb_q, stb_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q;
  logic              wr_ready_q, wr_ready_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [LEN_W-1:0]  len_eff;
  logic              expired;
  logic              stop;

  rtc_phase_timer #(
    .T_PHASE (T_PHASE)
  ) u_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .load    (state_d != state_q),
    .expired (expired)
  );

  always_comb begin
    if (cmd_len == '0)
      len_eff = LEN_W'(1);
    else if (cmd_len > LEN_W'(BURST_MAX))
      len_eff = LEN_W'(BURST_MAX);
    else
      len_eff = cmd_len;
  end

  // Burst ends when this was the last register or abort was seen.
  assign stop = (rem_q == LEN_W'(1)) || abort_q || abort;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rem_q       <= '0;
      abort_q     <= 1'b0;
      stb_q       <= STB_IDLE;
      oe_q        <= 1'b0;
      out_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rem_q       <= rem_d;
      abort_q     <= abort_d;
      stb_q       <= stb_d;
      oe_q        <= oe_d;
      out_q       <= out_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= ~cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rem_d      = rem_q;
    abort_d    = abort_q;
    wr_ready_d = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    if (state_q != S_IDLE)
      abort_d = abort_q | abort;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d = S_A_SET;
          write_d = cmd_write;
          addr_d  = cmd_addr;
          rem_d   = len_eff;
          abort_d = 1'b0;
        end
      end
      S_A_SET: if (expired) state_d = S_A_STB;
      S_A_STB: if (expired) state_d = S_A_HLD;
      S_A_HLD: begin
        if (expired && (!write_q || wr_valid)) begin
          state_d = S_D_SET;
          if (write_q) begin
            wr_ready_d = 1'b1;
            data_d     = wr_data;
          end
        end
      end
      S_D_SET: if (expired) state_d = S_D_STB;
      S_D_STB: begin
        if (expired) begin
          state_d = S_D_HLD;
          if (!write_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = bus_in;
          end
        end
      end
      S_D_HLD: if (expired) state_d = S_GAP;
      S_GAP: begin
        if (expired) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (stop) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            aborted_d = rem_q != LEN_W'(1);
          end else begin
            state_d = S_A_SET;
          end
        end
      end
    endcase
  end

  // Outputs decode the next state so the registered copy lines up with it.
  always_comb begin
    stb_d       = STB_IDLE;
    oe_d        = 1'b0;
    out_d       = '0;
    cmd_ready_d = (state_d == S_IDLE);
    unique case (state_d)
      S_A_SET, S_A_HLD: begin
        stb_d.cs = 1'b0;
        stb_d.ad = 1'b0;
        oe_d     = 1'b1;
        out_d    = addr_d;
      end
      S_A_STB: begin
        stb_d.cs = 1'b0;
        stb_d.ad = 1'b0;
        stb_d.wr = 1'b0;
        oe_d     = 1'b1;
        out_d    = addr_d;
      end
      S_D_SET, S_D_HLD: begin
        stb_d.cs = 1'b0;
        oe_d     = write_d;
        out_d    = write_d ? data_d : '0;
      end
      S_D_STB: begin
        stb_d.cs = 1'b0;
        stb_d.wr = ~write_d;
        stb_d.rd = write_d;
        oe_d     = write_d;
        out_d    = write_d ? data_d : '0;
      end
      default: ;
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign AD        = stb_q.ad;
  assign CS        = stb_q.cs;
  assign RD        = stb_q.rd;
  assign WR        = stb_q.wr;
  assign bus_out   = out_q;
  assign bus_oe    = oe_q;
  assign Data_Bus  = oe_q ? out_q : 'z;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: scoreboard bench with an RTC chip model.
// Random and directed bursts against a memory-level reference model.
module tb_rtc_bus_sequencer;
  import rtc_bus_pkg::*;

  localparam int T   = 4;
  localparam int BM  = 16;
  localparam int ACC = N_PHASES * T;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [4:0] cmd_len = '0;
  logic       abort = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       cmd_ready, wr_ready, rd_valid, busy, done, aborted;
  logic [7:0] rd_data, bus_out, bus_in;
  logic       AD, CS, RD, WR, bus_oe;
  wire  [7:0] data_bus;

  rtc_bus_sequencer #(
    .DATA_W(8), .T_PHASE(T), .BURST_MAX(BM), .LEN_W(5)
  ) dut (
    .Clk(clk), .Reset(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .abort(abort),
    .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done),
    .aborted(aborted), .AD(AD), .CS(CS), .RD(RD),
    .WR(WR), .bus_out(bus_out), .bus_oe(bus_oe),
    .bus_in(bus_in), .Data_Bus(data_bus)
  );

  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  int pass_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // RTC chip: latches the address on an address strobe, stores data
  // on a write data strobe, and serves bus_in from the latched address.
  logic [7:0] chip_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] chip_addr = '0;
  assign bus_in = chip_mem[chip_addr];

  always @(negedge clk) begin
    if (rst_n && !CS && !WR && !AD) chip_addr <= bus_out;
    if (rst_n && !CS && !WR && AD) chip_mem[chip_addr] <= bus_out;
  end

  logic [7:0] q_addr[$];
  logic [7:0] q_rd[$];
  logic [7:0] q_wd[$];
  int         q_adlen[$];
  int         q_abt[$];
  int         q_done_at[$];
  int         wr_rdy_cnt = 0;
  logic       prev_ad = 1'b1, prev_wr = 1'b1;
  int         ad_run = 0;

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      prev_ad = 1'b1;
      prev_wr = 1'b1;
      ad_run  = 0;
    end else begin
      if (!AD && prev_ad) begin
        ad_run = 1;
        if (q_addr.size() == 0) chk("addr_unexpected", 1, 0);
        else begin
          e = q_addr.pop_front();
          chk("addr_phase", int'(bus_out), int'(e));
          chk("addr_on_data_bus", int'(data_bus), int'(e));
        end
      end else if (!AD) ad_run++;
      if (AD && !prev_ad) begin
        if (q_adlen.size() == 0) chk("ad_len_unexpected", 1, 0);
        else chk("ad_low_cycles", ad_run, q_adlen.pop_front());
      end
      if (!AD && !WR && prev_wr)
        chk("addr_wr_fall_cycle", ad_run, T + 1);
      if (!AD && WR && !prev_wr)
        chk("addr_wr_rise_cycle", ad_run, 2 * T + 1);
      if (AD && !CS && !WR && prev_wr) begin
        chk("wdata_oe", int'(bus_oe), 1);
        if (q_wd.size() == 0) chk("wdata_unexpected", 1, 0);
        else chk("wdata_bus", int'(bus_out), int'(q_wd.pop_front()));
      end
      if (!RD) chk("rd_vs_oe", int'(bus_oe), 0);
      if (rd_valid) begin
        if (q_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_data", int'(rd_data), int'(q_rd.pop_front()));
      end
      if (wr_ready) wr_rdy_cnt++;
      if (done) begin
        if (q_abt.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          chk("done_aborted", int'(aborted), q_abt.pop_front());
          chk("done_cycle", ncyc, q_done_at.pop_front());
        end
      end
      prev_ad = AD;
      prev_wr = WR;
    end
  end

  // abort_at: access (1-based) during which abort is pulsed, 0 = none.
  // stall: extra cycles wr_valid stays low on the first write access.
  task automatic run_cmd(input bit wr, input logic [7:0] addr,
                         input logic [4:0] len, input int abort_at,
                         input int stall, input int wd0);
    int n, ncomp, t0, w0, wi;
    bit got;
    logic [7:0] a, d;
    logic [7:0] wd[$];
    n = (len == 0) ? 1 : ((int'(len) > BM) ? BM : int'(len));
    ncomp = (abort_at > 0 && abort_at < n) ? abort_at : n;
    a = addr;
    for (int i = 0; i < ncomp; i++) begin
      q_addr.push_back(a);
      q_adlen.push_back((i == 0 && wr) ? 3 * T + stall : 3 * T);
      if (wr) begin
        d = (i == 0 && wd0 >= 0) ? 8'(wd0) : 8'($urandom);
        wd.push_back(d);
        q_wd.push_back(d);
        ref_mem[a] = d;
      end else begin
        q_rd.push_back(ref_mem[a]);
      end
      a = a + 8'd1;
    end
    q_abt.push_back(int'(ncomp < n));
    @(negedge clk);
    for (int g = 0; g < 50 && !cmd_ready; g++) @(negedge clk);
    t0 = ncyc;
    q_done_at.push_back(t0 + ncomp * ACC + 1 + stall);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    wr_valid  = wr && (stall == 0);
    if (wr) wr_data = wd[0];
    w0 = wr_rdy_cnt;
    wi = 0;
    got = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_len   = 5'($urandom);
    for (int k = 0; k < ncomp * ACC + stall + 50; k++) begin
      @(negedge clk);
      abort = (abort_at > 0) &&
              (ncyc == t0 + (abort_at - 1) * ACC + 5);
      if (wr && stall > 0 && ncyc == t0 + 3 * T + 5) begin
        chk("stall_cs", int'(CS), 0);
        chk("stall_wr", int'(WR), 1);
        chk("stall_ad", int'(AD), 0);
      end
      if (wr && stall > 0 && ncyc == t0 + 3 * T + stall)
        wr_valid = 1'b1;
      if (wr_ready) begin
        wi++;
        if (wi < wd.size()) wr_data = wd[wi];
        else wr_valid = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    abort = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("ready_after_done", int'(cmd_ready), 1);
    chk("busy_after_done", int'(busy), 0);
    if (wr) chk("wr_ready_pulses", wr_rdy_cnt - w0, ncomp);
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]  = 8'($urandom);
      chip_mem[i] = ref_mem[i];
    end
    for (int i = 0; i < 3; i++) begin
      ref_mem[8'h23 + i]  = 8'h10 + 8'(i);
      chip_mem[8'h23 + i] = 8'h10 + 8'(i);
    end
    repeat (3) @(negedge clk);
    chk("rst_cs", int'(CS), 1);
    chk("rst_ad", int'(AD), 1);
    chk("rst_rd", int'(RD), 1);
    chk("rst_wr", int'(WR), 1);
    chk("rst_oe", int'(bus_oe), 0);
    chk("rst_bus_out", int'(bus_out), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'({wr_ready, rd_valid, done, aborted}), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    rst_n = 1'b1;

    run_cmd(1'b1, 8'h21, 5'd1, 0, 0, 'h45);
    run_cmd(1'b0, 8'h23, 5'd3, 0, 0, -1);
    run_cmd(1'b1, 8'hFF, 5'd2, 0, 0, -1);
    run_cmd(1'b1, 8'h40, 5'd1, 0, 10, -1);
    run_cmd(1'b0, 8'h50, 5'd16, 2, 0, -1);
    run_cmd(1'b0, 8'h21, 5'd0, 0, 0, -1);

    @(negedge clk);
    t0 = ncyc;
    q_addr.push_back(8'h30);
    q_adlen.push_back(3 * T);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h30;
    cmd_len   = 5'd1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    while (ncyc < t0 + 4 * T + 2) @(negedge clk);
    chk("dstb_rd_low", int'(RD), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cs", int'(CS), 1);
    chk("arst_ad", int'(AD), 1);
    chk("arst_rd", int'(RD), 1);
    chk("arst_wr", int'(WR), 1);
    chk("arst_oe", int'(bus_oe), 0);
    chk("arst_ready", int'(cmd_ready), 1);
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    run_cmd(1'b1, 8'h31, 5'd1, 0, 0, -1);

    for (int i = 0; i < 16; i++)
      run_cmd(1'($urandom), 8'($urandom),
              5'($urandom_range(0, 31)), 0, 0, -1);

    repeat (5) @(negedge clk);
    chk("queues_empty",
        q_addr.size() + q_rd.size() + q_wd.size() +
        q_adlen.size() + q_abt.size() + q_done_at.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
